// File: rtl/seq_array_mul_pkg.sv
// ----------------------------------------------------------------------------
// seq_array_mul_pkg
//   Shared types and helpers for the sequential array multiplier.
//   - state_t             : controller state encoding (IDLE/CALC/DONE)
//   - calc_cycles()       : number of CALC clocks for an M-bit multiplier, K bits/clock
//   - cnt_width()         : width of the chunk counter
//   - SEQ_ARRAY_MUL_CFG_OK: N/M/K legality expression used at elaboration
// ----------------------------------------------------------------------------
`ifndef SEQ_ARRAY_MUL_CFG_OK
`define SEQ_ARRAY_MUL_CFG_OK(n, m, k) (((n) >= 2) && ((m) >= 2) && ((k) >= 1) && (((m) % (k)) == 0))
`endif

package seq_array_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clocks spent in CALC when no early termination applies.
    function automatic int unsigned calc_cycles(input int unsigned m, input int unsigned k);
        return m / k;
    endfunction

    // Counter must hold 0..CYC.
    function automatic int unsigned cnt_width(input int unsigned m, input int unsigned k);
        return $clog2((m / k) + 1);
    endfunction

endpackage

// File: rtl/seq_array_mul_if.sv
// ----------------------------------------------------------------------------
// seq_array_mul_if
//   Operand/result handshake bundle for seq_array_mul.
//   Operand side : in_valid, in_ready, A (N), B (M), sg
//   Result side  : out_valid, out_ready, Y (N+M)
//   master = producer of operands / consumer of results, slave = multiplier.
// ----------------------------------------------------------------------------
interface seq_array_mul_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [M-1:0]     B;
    logic             sg;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   Y;

    modport master (
        output in_valid, A, B, sg, out_ready,
        input  in_ready, out_valid, Y
    );

    modport slave (
        input  in_valid, A, B, sg, out_ready,
        output in_ready, out_valid, Y
    );
endinterface

// File: rtl/seq_array_mul_pp_chunk.sv
// ----------------------------------------------------------------------------
// seq_array_mul_pp_chunk
//   Combinational partial-product term for one K-bit multiplier chunk.
//   Ports:
//     a_ext  in  W  multiplicand, extended to W and pre-shifted to the chunk position
//     chunk  in  K  current multiplier bits (LSB first)
//     last   in  1  this is the most-significant chunk
//     sg     in  1  signed operation
//     term_c out W  sum of a_ext<<j for set chunk bits, mod 2^W
//   In signed mode the top multiplier bit weighs -2^(M-1), so on the last
//   chunk its contribution is subtracted instead of added.
// ----------------------------------------------------------------------------
module seq_array_mul_pp_chunk
    import seq_array_mul_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned K = 1
) (
    input  logic [W-1:0] a_ext,
    input  logic [K-1:0] chunk,
    input  logic         last,
    input  logic         sg,
    output logic [W-1:0] term_c
);

    // Shift-and-add over the chunk bits; the sign bit of B negates its row.
    always_comb begin
        term_c = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (chunk[j]) begin
                if (sg && last && (j == K - 1)) begin
                    term_c = term_c - (a_ext << j);
                end else begin
                    term_c = term_c + (a_ext << j);
                end
            end
        end
    end

endmodule

// File: rtl/seq_array_mul.sv
// ----------------------------------------------------------------------------
// seq_array_mul
//   Multi-cycle NxM multiplier producing the exact N+M-bit product, signed or
//   unsigned per operation, retiring K multiplier bits per clock.
//   Ports:
//     clk   in  1   clock, rising edge
//     rst   in  1   synchronous active-high reset
//     bus   slave   seq_array_mul_if: in_valid/in_ready/A/B/sg, out_valid/out_ready/Y
//     busy  out 1   high while in CALC
//   Latency accept -> out_valid is M/K clocks.
//   Build option MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier
//   bits are all zero (latency 1..M/K); the product is identical either way.
// ----------------------------------------------------------------------------
module seq_array_mul
    import seq_array_mul_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4,
    parameter int unsigned K = 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_array_mul_if.slave  bus,
    output logic            busy
);

    localparam int unsigned W   = N + M;
    localparam int unsigned CYC = calc_cycles(M, K);
    localparam int unsigned CW  = cnt_width(M, K);

    if (!(`SEQ_ARRAY_MUL_CFG_OK(N, M, K))) begin : g_cfg_check
        $error("seq_array_mul: illegal N/M/K (need N>=2, M>=2, M%%K==0)");
    end

    state_t          state;
    logic [W-1:0]    a_sh;       // extended multiplicand, shifted left K per chunk
    logic [M-1:0]    b_rem;      // multiplier, shifted right K per chunk
    logic            sg_q;
    logic [W-1:0]    acc;
    logic [W-1:0]    y_q;
    logic            out_valid_q;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    term_c;
    logic [W-1:0]    acc_sum_c;
    logic [W-1:0]    a_ext_c;
    logic            last_c;
    logic            finish_c;
    logic            accept_c;

    // Handshake
    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign accept_c      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Y         = y_q;

    // Sign- or zero-extend A to the product width
    assign a_ext_c = {{M{bus.sg & bus.A[N-1]}}, bus.A};

    assign last_c    = (cnt == CW'(CYC - 1));
    assign acc_sum_c = acc + term_c;

`ifdef MUL_EARLY_TERM_EN
    // Nothing left above this chunk: the product is complete now.
    // A negative signed B keeps its MSB set, so it always runs to the last chunk.
    assign finish_c = last_c || ((b_rem >> K) == '0);
`else
    assign finish_c = last_c;
`endif

    seq_array_mul_pp_chunk #(
        .W (W),
        .K (K)
    ) u_pp_chunk (
        .a_ext  (a_sh),
        .chunk  (b_rem[K-1:0]),
        .last   (last_c),
        .sg     (sg_q),
        .term_c (term_c)
    );

    // Controller, counter and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_sh        <= '0;
            b_rem       <= '0;
            sg_q        <= 1'b0;
            acc         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_CALC: begin
                    if (finish_c) begin
                        y_q         <= acc_sum_c;
                        out_valid_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        acc   <= acc_sum_c;
                        cnt   <= cnt + CW'(1);
                        a_sh  <= a_sh << K;
                        b_rem <= b_rem >> K;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Accept only happens from IDLE or from DONE with out_ready;
            // it overrides the IDLE transition for back-to-back operation.
            if (accept_c) begin
                a_sh  <= a_ext_c;
                b_rem <= bus.B;
                sg_q  <= bus.sg;
                acc   <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= ST_CALC;
            end
        end
    end

endmodule

// File: tb/tb_seq_array_mul.sv
// ----------------------------------------------------------------------------
// tb_seq_array_mul
//   Two instances: 4x4 with K=1 and 8x8 with K=2. Directed cases plus random
//   operands compared with an integer-arithmetic reference product and an
//   expected latency derived from the multiplier bit pattern.
// ----------------------------------------------------------------------------
module tb_seq_array_mul;

    logic clk = 1'b0;
    logic rst;
    logic busy0, busy1;

    always #5 clk = ~clk;

    seq_array_mul_if #(.N(4), .M(4)) if0 ();
    seq_array_mul_if #(.N(8), .M(8)) if1 ();

    seq_array_mul #(.N(4), .M(4), .K(1)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if0.slave),
        .busy (busy0)
    );

    seq_array_mul #(.N(8), .M(8), .K(2)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if1.slave),
        .busy (busy1)
    );

`ifdef MUL_EARLY_TERM_EN
    localparam int LAT_SHORT = 1;
`else
    localparam int LAT_SHORT = 4;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact product from the operand values, truncated to n+m bits
    function automatic logic [15:0] ref_mul(input int n, input int m, input logic [7:0] a,
                                            input logic [7:0] b, input logic s);
        longint av;
        longint bv;
        longint p;
        av = longint'(a);
        bv = longint'(b);
        if (s && a[n-1]) av = av - (longint'(1) << n);
        if (s && b[m-1]) bv = bv - (longint'(1) << m);
        p = av * bv;
        return 16'(p & ((longint'(1) << (n + m)) - 1));
    endfunction

    // Clocks from accept to out_valid
    function automatic int ref_lat(input int m, input int k, input logic [7:0] b);
        int top;
        int c;
        top = 0;
        for (int i = 0; i < m; i++) if (b[i]) top = i + 1;
        c = (top + k - 1) / k;
`ifdef MUL_EARLY_TERM_EN
        return (c < 1) ? 1 : c;
`else
        return m / k;
`endif
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel != 0) ? if1.out_valid : if0.out_valid;
    endfunction

    function automatic logic get_ir(input int sel);
        return (sel != 0) ? if1.in_ready : if0.in_ready;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic [15:0] get_y(input int sel);
        return (sel != 0) ? if1.Y : 16'(if0.Y);
    endfunction

    task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic v);
        if (sel == 0) begin
            if0.A = a[3:0]; if0.B = b[3:0]; if0.sg = s; if0.in_valid = v;
        end else begin
            if1.A = a; if1.B = b; if1.sg = s; if1.in_valid = v;
        end
    endtask

    task automatic set_ordy(input int sel, input logic r);
        if (sel == 0) if0.out_ready = r;
        else          if1.out_ready = r;
    endtask

    // Called #1 after a rising edge; returns at #1 after the edge raising out_valid
    task automatic wait_result(input int sel, output logic [15:0] y, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!get_ov(sel) && lat < 40);
        check("out_valid_seen", 64'(get_ov(sel)), 64'(1));
        y = get_y(sel);
    endtask

    task automatic do_op(input int sel, input logic [7:0] a_in, input logic [7:0] b_in,
                         input logic s, input int hold, output logic [15:0] y, output int lat);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int n;
        n = (sel != 0) ? 8 : 4;
        a = (sel != 0) ? a_in : (a_in & 8'h0F);
        b = (sel != 0) ? b_in : (b_in & 8'h0F);
        exp = ref_mul(n, n, a, b, s);
        drive(sel, a, b, s, 1'b1);
        check("in_ready_idle", 64'(get_ir(sel)), 64'(1));
        @(posedge clk); #1;
        // operands change after accept must not affect the result
        drive(sel, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        check("busy_calc", 64'(get_busy(sel)), 64'(1));
        wait_result(sel, y, lat);
        check("Y_ref", 64'(y), 64'(exp));
        check("latency", 64'(lat), 64'(ref_lat(n, (sel != 0) ? 2 : 1, b)));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("Y_hold", 64'(get_y(sel)), 64'(exp));
            check("ov_hold", 64'(get_ov(sel)), 64'(1));
        end
        set_ordy(sel, 1'b1);
        @(posedge clk); #1;
        set_ordy(sel, 1'b0);
        check("ov_drop", 64'(get_ov(sel)), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] y;
        int lat;

        rst = 1'b1;
        drive(0, 8'h0, 8'h0, 1'b0, 1'b0);
        drive(1, 8'h0, 8'h0, 1'b0, 1'b0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        for (int s = 0; s < 2; s++) begin
            check("rst_Y", 64'(get_y(s)), 64'(0));
            check("rst_ov", 64'(get_ov(s)), 64'(0));
            check("rst_busy", 64'(get_busy(s)), 64'(0));
            check("rst_in_ready", 64'(get_ir(s)), 64'(1));
        end

        // Unsigned max
        do_op(0, 8'h0F, 8'h0F, 1'b0, 0, y, lat);
        check("t1_Y", 64'(y), 64'h00E1);
        check("t1_lat", 64'(lat), 64'(4));

        // Signed corners
        do_op(0, 8'h08, 8'h08, 1'b1, 0, y, lat);
        check("t2a_Y", 64'(y), 64'h0040);
        do_op(0, 8'h0F, 8'h07, 1'b1, 0, y, lat);
        check("t2b_Y", 64'(y), 64'h00F9);
        do_op(0, 8'h07, 8'h08, 1'b1, 0, y, lat);
        check("t2c_Y", 64'(y), 64'h00C8);

        // Backpressure and back-to-back accept
        drive(0, 8'h03, 8'h05, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'h09, 8'h06, 1'b0, 1'b1);
        check("t3_in_ready_calc", 64'(if0.in_ready), 64'(0));
        wait_result(0, y, lat);
        check("t3_Y1", 64'(y), 64'h000F);
        check("t3_lat1", 64'(lat), 64'(ref_lat(4, 1, 8'h05)));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t3_Y_stable", 64'(if0.Y), 64'h000F);
            check("t3_ov_stable", 64'(if0.out_valid), 64'(1));
            check("t3_in_ready_done", 64'(if0.in_ready), 64'(0));
        end
        set_ordy(0, 1'b1);
        #1;
        check("t3_in_ready_release", 64'(if0.in_ready), 64'(1));
        @(posedge clk); #1;
        drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
        set_ordy(0, 1'b0);
        check("t3_ov_after", 64'(if0.out_valid), 64'(0));
        check("t3_busy_b2b", 64'(busy0), 64'(1));
        wait_result(0, y, lat);
        check("t3_Y2", 64'(y), 64'h0036);
        check("t3_lat2", 64'(lat), 64'(ref_lat(4, 1, 8'h06)));
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        set_ordy(0, 1'b0);

        // Reset mid-CALC at cnt=2
        drive(0, 8'h07, 8'h0E, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_Y", 64'(if0.Y), 64'(0));
        check("t4_ov", 64'(if0.out_valid), 64'(0));
        check("t4_in_ready", 64'(if0.in_ready), 64'(1));
        check("t4_busy", 64'(busy0), 64'(0));

        // 8x8, K=2 signed min*min
        do_op(1, 8'h80, 8'h80, 1'b1, 0, y, lat);
        check("t5_Y", 64'(y), 64'h4000);
        check("t5_lat", 64'(lat), 64'(4));

        // Short multipliers (early termination when enabled)
        do_op(0, 8'h05, 8'h01, 1'b0, 0, y, lat);
        check("t6a_Y", 64'(y), 64'h0005);
        check("t6a_lat", 64'(lat), 64'(LAT_SHORT));
        do_op(0, 8'h05, 8'h00, 1'b0, 0, y, lat);
        check("t6b_Y", 64'(y), 64'h0000);
        check("t6b_lat", 64'(lat), 64'(LAT_SHORT));

        // Random sweep on both instances
        for (int i = 0; i < 40; i++) begin
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), y, lat);
        end
        for (int i = 0; i < 40; i++) begin
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), y, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
